// File: rtl/regfile_access_ctrl.sv
// Register-file port-1 owner: arbitrates core and debug accesses and runs a
// zero-clear sweep of the general-purpose registers after reset or on command.
module regfile_access_ctrl #(
    parameter int n        = 8,
    parameter int FIRST_GP = 3,
    parameter int LAST_REG = 31,
    parameter int MAX_WAIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_req,
    input  logic         core_req,
    input  logic         core_we,
    input  logic [4:0]   core_addr,
    input  logic [n-1:0] core_wdata,
    output logic         core_gnt,
    output logic [n-1:0] core_rdata,
    input  logic         dbg_req,
    input  logic         dbg_we,
    input  logic [4:0]   dbg_addr,
    input  logic [n-1:0] dbg_wdata,
    output logic         dbg_gnt,
    output logic         dbg_rvalid,
    output logic [n-1:0] dbg_rdata,
    output logic         wr_err,
    output logic         rf_w,
    output logic [4:0]   rf_addr,
    output logic [n-1:0] rf_wdata,
    input  logic [n-1:0] rf_rdata,
    output logic         busy
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [4:0]    FIRST_A = 5'(FIRST_GP);
    localparam logic [4:0]    LAST_A  = 5'(LAST_REG);
    localparam logic [WW-1:0] MAXW    = WW'(MAX_WAIT);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state_q, state_d;
    logic [4:0]    clr_ptr_q, clr_ptr_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          dbg_rvalid_q;
    logic [n-1:0]  dbg_rdata_q;
    logic          wr_err_q;

    logic          run;
    logic          dbg_force;
    logic          acc;
    logic          sel_we;
    logic [4:0]    sel_addr;
    logic [n-1:0]  sel_wdata;
    logic          wr_low;

    // Arbitration: core wins unless debug has waited MAX_WAIT cycles; then pick the winner's fields.
    always_comb begin
        run       = (state_q == RUN);
        dbg_force = dbg_req && (wait_cnt_q == MAXW);
        core_gnt  = run && core_req && !dbg_force;
        dbg_gnt   = run && dbg_req && !core_gnt;
        acc       = core_gnt || dbg_gnt;
        sel_we    = core_gnt ? core_we    : dbg_we;
        sel_addr  = core_gnt ? core_addr  : dbg_addr;
        sel_wdata = core_gnt ? core_wdata : dbg_wdata;
        wr_low    = acc && sel_we && (sel_addr < FIRST_A);
    end

    // Register-file port drive: sweep writes in CLEAR, granted access in RUN, quiet otherwise.
    always_comb begin
        rf_w     = 1'b0;
        rf_addr  = 5'd0;
        rf_wdata = '0;
        if (!run) begin
            rf_w    = 1'b1;
            rf_addr = clr_ptr_q;
        end else if (acc) begin
            rf_addr  = sel_addr;
            rf_w     = sel_we && (sel_addr >= FIRST_A);
            rf_wdata = sel_we ? sel_wdata : '0;
        end
    end

    // Next-state for the sweep FSM and the debug starvation counter.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (!run) begin
            clr_ptr_d = clr_ptr_q + 5'd1;
            if (clr_ptr_q == LAST_A) state_d = RUN;
        end else if (clear_req) begin
            state_d   = CLEAR;
            clr_ptr_d = FIRST_A;
        end
        if (dbg_req && !dbg_gnt)
            wait_cnt_d = (wait_cnt_q == MAXW) ? wait_cnt_q : wait_cnt_q + WW'(1);
        else
            wait_cnt_d = '0;
    end

    // State and registered debug/error outputs; reset restarts the sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= CLEAR;
            clr_ptr_q    <= FIRST_A;
            wait_cnt_q   <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            wait_cnt_q   <= wait_cnt_d;
            dbg_rvalid_q <= dbg_gnt && !dbg_we;
            if (dbg_gnt && !dbg_we) dbg_rdata_q <= rf_rdata;
            wr_err_q     <= wr_low;
        end
    end

    assign core_rdata = rf_rdata;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign wr_err     = wr_err_q;
    assign busy       = !run;

endmodule
